// File: rtl/weight_enum_if.sv
// Stream and control bundle for the weight enumerator.
interface weight_enum_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned POS_W  = $clog2(DATA_W + 1)
);
    logic              start;
    logic [POS_W-1:0]  k;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_word;
    logic              out_last;
    logic [DATA_W-1:0] out_idx;
    logic              busy;
    logic              done;
    logic              err;

    // Controller / consumer side
    modport master (
        output start, k, abort, out_ready,
        input  out_valid, out_word, out_last, out_idx, busy, done, err
    );

    // Enumerator side
    modport slave (
        input  start, k, abort, out_ready,
        output out_valid, out_word, out_last, out_idx, busy, done, err
    );
endinterface

// File: rtl/weight_enum.sv
// Streams every DATA_W-bit word of Hamming weight k in ascending order,
// one word per clock, using the next-combination (Gosper) rule.
module weight_enum #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned POS_W  = $clog2(DATA_W + 1)
) (
    input  logic            clk,
    input  logic            rst,
    weight_enum_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_word_q, out_word_d;
    logic              out_last_q, out_last_d;
    logic [DATA_W-1:0] out_idx_q, out_idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] last_mask_q, last_mask_d;

    logic [POS_W-1:0]  k_in;
    logic              hs;
    logic [DATA_W-1:0] lsb_c;
    logic [DATA_W:0]   ripple_c;
    logic [DATA_W:0]   tail_c;
    logic [DATA_W-1:0] succ_c;
    int unsigned       tz_c;
    logic              tz_found;

    // Words with the n lowest bits set (n <= DATA_W)
    function automatic logic [DATA_W-1:0] low_ones(input int unsigned n);
        logic [DATA_W:0] t;
        t = ((DATA_W + 1)'(1) << n) - (DATA_W + 1)'(1);
        return t[DATA_W-1:0];
    endfunction

    assign k_in = bus.k;
    assign hs   = out_valid_q & bus.out_ready;

    // Next word of equal weight: add lowest set bit, refill the low ones
    always_comb begin
        tz_c     = 0;
        tz_found = 1'b0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (!tz_found && out_word_q[i]) begin
                tz_c     = i;
                tz_found = 1'b1;
            end
        end
        lsb_c    = out_word_q & (-out_word_q);
        ripple_c = {1'b0, out_word_q} + {1'b0, lsb_c};
        tail_c   = (ripple_c ^ {1'b0, out_word_q}) >> (tz_c + 32'd2);
        succ_c   = ripple_c[DATA_W-1:0] | tail_c[DATA_W-1:0];
    end

    // State and output next-value logic
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        last_mask_d = last_mask_q;

        case (state_q)
            S_IDLE: begin
                // abort is meaningless here, so a same-cycle start always wins
                if (bus.start) begin
                    if (32'(k_in) > DATA_W) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = S_EMIT;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        out_word_d  = low_ones(32'(k_in));
                        out_idx_d   = '0;
                        last_mask_d = ~low_ones(DATA_W - 32'(k_in));
                        out_last_d  = (low_ones(32'(k_in)) == ~low_ones(DATA_W - 32'(k_in)));
                    end
                end
            end
            S_EMIT: begin
                if (bus.abort) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                    out_word_d  = '0;
                    out_idx_d   = '0;
                end else if (hs) begin
                    if (out_last_q) begin
                        state_d     = S_FIN;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        out_word_d = succ_c;
                        out_idx_d  = out_idx_q + DATA_W'(1);
                        out_last_d = (succ_c == last_mask_q);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            last_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_mask_q <= last_mask_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_weight_enum.sv
// Bench for weight_enum: a table of DATA_W=4 vectors plus directed
// multi-cycle sequences on a DATA_W=10 instance.
module tb_weight_enum;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    weight_enum_if #(.DATA_W(4))  bus4 ();
    weight_enum_if #(.DATA_W(10)) bus10 ();

    weight_enum #(.DATA_W(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
    weight_enum #(.DATA_W(10)) u_dut10 (.clk(clk), .rst(rst), .bus(bus10));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [2:0] k;
        logic       rdy;
        logic       ev;
        logic [3:0] ew;
        logic [3:0] ei;
        logic       el;
        logic       eb;
        logic       ed;
        logic       ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic [2:0] k, input logic rdy,
                                input logic ev, input logic [3:0] ew, input logic [3:0] ei,
                                input logic el, input logic eb, input logic ed, input logic ee);
        vec_t v;
        v.st = st; v.k = k; v.rdy = rdy; v.ev = ev; v.ew = ew; v.ei = ei;
        v.el = el; v.eb = eb; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    // Reference successor: smallest larger word with the same popcount
    function automatic logic [9:0] next_pop(input logic [9:0] x, input int kk);
        logic [10:0] y;
        y = {1'b0, x} + 11'd1;
        for (int n = 0; n < 1024; n++) begin
            if ($countones(y) == kk || y >= 11'd1024) break;
            y = y + 11'd1;
        end
        return y[9:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero10(input string tag);
        chk({tag, "_valid"}, 32'(bus10.out_valid), 32'd0);
        chk({tag, "_word"},  32'(bus10.out_word),  32'd0);
        chk({tag, "_idx"},   32'(bus10.out_idx),   32'd0);
        chk({tag, "_last"},  32'(bus10.out_last),  32'd0);
        chk({tag, "_busy"},  32'(bus10.busy),      32'd0);
        chk({tag, "_done"},  32'(bus10.done),      32'd0);
        chk({tag, "_err"},   32'(bus10.err),       32'd0);
    endtask

    initial begin
        logic [9:0] expw;
        logic [9:0] last_acc;
        logic [9:0] prev_word;
        logic       prev_stall;
        logic       rdy;
        logic       seen_done;
        int         n;
        int         cyc;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus4.start = 1'b0;  bus4.k = '0;  bus4.abort = 1'b0;  bus4.out_ready = 1'b0;
        bus10.start = 1'b0; bus10.k = '0; bus10.abort = 1'b0; bus10.out_ready = 1'b0;

        // Reset values
        #3;
        chk_zero10("rst0");
        chk("rst0_valid4", 32'(bus4.out_valid), 32'd0);
        chk("rst0_busy4",  32'(bus4.busy),      32'd0);
        step();
        rst = 1'b0;
        step();

        // DATA_W=4 table: st k rdy | valid word idx last busy done err
        tbl.push_back(mk(1, 3'd2, 1, 1, 4'h3, 4'd0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 1, 4'h5, 4'd1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 0, 1, 4'h5, 4'd1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 3'd1, 1, 1, 4'h6, 4'd2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 1, 4'h9, 4'd3, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 1, 4'hA, 4'd4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 0, 1, 4'hA, 4'd4, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 1, 4'hC, 4'd5, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 0, 1, 4'hC, 4'd5, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 0, 4'h0, 4'd0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 0, 4'h0, 4'd0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'd0, 0, 1, 4'h0, 4'd0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 0, 1, 4'h0, 4'd0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 0, 4'h0, 4'd0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 0, 4'h0, 4'd0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'd4, 0, 1, 4'hF, 4'd0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 0, 4'h0, 4'd0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 0, 4'h0, 4'd0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'd5, 0, 0, 4'h0, 4'd0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 3'd0, 0, 0, 4'h0, 4'd0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3'd3, 1, 1, 4'h7, 4'd0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 1, 4'hB, 4'd1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 1, 4'hD, 4'd2, 0, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 1, 4'hE, 4'd3, 1, 1, 0, 0));
        tbl.push_back(mk(0, 3'd0, 1, 0, 4'h0, 4'd0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 3'd0, 0, 0, 4'h0, 4'd0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            bus4.start     = tbl[i].st;
            bus4.k         = tbl[i].k;
            bus4.out_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), 32'(bus4.out_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_busy", i),  32'(bus4.busy),      32'(tbl[i].eb));
            chk($sformatf("v%0d_done", i),  32'(bus4.done),      32'(tbl[i].ed));
            chk($sformatf("v%0d_err", i),   32'(bus4.err),       32'(tbl[i].ee));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_word", i), 32'(bus4.out_word), 32'(tbl[i].ew));
                chk($sformatf("v%0d_idx", i),  32'(bus4.out_idx),  32'(tbl[i].ei));
                chk($sformatf("v%0d_last", i), 32'(bus4.out_last), 32'(tbl[i].el));
            end
        end
        bus4.start = 1'b0;
        bus4.out_ready = 1'b0;

        // DATA_W=10, k=5 with random back-pressure
        bus10.start = 1'b1;
        bus10.k     = 4'd5;
        step();
        bus10.start = 1'b0;
        n          = 0;
        expw       = 10'h01F;
        last_acc   = '0;
        prev_word  = '0;
        prev_stall = 1'b0;
        seen_done  = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (bus10.done) begin
                seen_done = 1'b1;
                break;
            end
            if (bus10.out_valid) begin
                chk("k5_word", 32'(bus10.out_word), 32'(expw));
                chk("k5_idx",  32'(bus10.out_idx),  32'(n));
                chk("k5_last", 32'(bus10.out_last), 32'(expw == 10'h3E0));
                chk("k5_pop",  32'($countones(bus10.out_word)), 32'd5);
                if (prev_stall)
                    chk("k5_stable", 32'(bus10.out_word), 32'(prev_word));
            end
            rdy = 1'($urandom_range(0, 1));
            bus10.out_ready = rdy;
            prev_stall = bus10.out_valid && !rdy;
            prev_word  = bus10.out_word;
            if (bus10.out_valid && rdy) begin
                if (n > 0)
                    chk("k5_ascend", 32'(bus10.out_word > last_acc), 32'd1);
                last_acc = bus10.out_word;
                n++;
                if (expw != 10'h3E0)
                    expw = next_pop(expw, 5);
            end
            step();
        end
        chk("k5_done_seen", 32'(seen_done), 32'd1);
        chk("k5_count",     32'(n),         32'd252);
        chk("k5_final",     32'(last_acc),  32'h3E0);
        chk("k5_busy_fin",  32'(bus10.busy), 32'd1);
        step();
        chk("k5_done_1clk", 32'(bus10.done), 32'd0);
        chk("k5_busy_idle", 32'(bus10.busy), 32'd0);

        // Abort at idx 3 coinciding with a handshake
        bus10.out_ready = 1'b1;
        bus10.start     = 1'b1;
        bus10.k         = 4'd2;
        step();
        bus10.start = 1'b0;
        for (cyc = 0; cyc < 20 && bus10.out_idx != 10'd3; cyc++)
            step();
        chk("ab_idx3",  32'(bus10.out_idx),  32'd3);
        chk("ab_word3", 32'(bus10.out_word), 32'h009);
        bus10.abort = 1'b1;
        step();
        bus10.abort = 1'b0;
        chk("ab_valid", 32'(bus10.out_valid), 32'd0);
        chk("ab_busy",  32'(bus10.busy),      32'd0);
        chk("ab_done",  32'(bus10.done),      32'd0);
        step();
        chk("ab_done2", 32'(bus10.done), 32'd0);
        bus10.start = 1'b1;
        bus10.k     = 4'd1;
        bus10.abort = 1'b1;
        step();
        bus10.start = 1'b0;
        bus10.abort = 1'b0;
        chk("ab_k1_valid", 32'(bus10.out_valid), 32'd1);
        chk("ab_k1_word",  32'(bus10.out_word),  32'h001);
        chk("ab_k1_idx",   32'(bus10.out_idx),   32'd0);
        chk("ab_k1_last",  32'(bus10.out_last),  32'd0);
        step();
        chk("ab_k1_word2", 32'(bus10.out_word), 32'h002);
        bus10.abort = 1'b1;
        step();
        bus10.abort = 1'b0;
        chk("ab_k1_busy", 32'(bus10.busy), 32'd0);

        // k=3 with start held (ignored while busy), then async reset at idx 7
        bus10.start = 1'b1;
        bus10.k     = 4'd3;
        step();
        expw = 10'h007;
        bus10.k = 4'd1;
        for (cyc = 0; cyc < 20 && bus10.out_idx != 10'd7; cyc++) begin
            chk("k3_word", 32'(bus10.out_word), 32'(expw));
            chk("k3_busy", 32'(bus10.busy), 32'd1);
            expw = next_pop(expw, 3);
            step();
        end
        chk("k3_idx7",  32'(bus10.out_idx),  32'd7);
        chk("k3_word7", 32'(bus10.out_word), 32'h019);
        bus10.start = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_zero10("arst");
        step();
        rst = 1'b0;
        chk_zero10("arst_hold");
        step();
        chk("post_rst_done", 32'(bus10.done), 32'd0);
        chk("post_rst_err",  32'(bus10.err),  32'd0);
        chk("post_rst_busy", 32'(bus10.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
